// File: rtl/irq_pkg.sv
// Shared constants for the interrupt front end and the interrupt controller.
package irq_pkg;

    localparam int N_SRC = 6;
    localparam int CNT_W = 4;

    localparam int IRQ_SRC_0 = 0;
    localparam int IRQ_SRC_1 = 1;
    localparam int IRQ_SRC_2 = 2;
    localparam int IRQ_SRC_3 = 3;
    localparam int IRQ_SRC_4 = 4;
    localparam int IRQ_SRC_5 = 5;

    // 1 = rising-edge latched, 0 = level following
    localparam logic [N_SRC-1:0] EDGE_MODE_DEFAULT = 6'b111111;

endpackage

// File: rtl/irq_src_channel.sv
// One interrupt source: synchroniser, edge detect, pending flop and
// saturating missed-event counter.
module irq_src_channel #(
    parameter int   SYNC_STAGES = 2,
    parameter logic EDGE        = 1'b1,
    parameter int   CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_raw_i,
    input  logic             int_fin_i,
    input  logic             miss_clr_i,
    output logic             pend_o,
    output logic             pend_next_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q;
    logic                   pend_d;
    logic [CNT_W-1:0]       missCnt_q;
    logic [CNT_W-1:0]       missCnt_d;
    logic                   syncOut;
    logic                   rise;

    assign syncOut = sync_q[SYNC_STAGES-1];
    assign rise    = syncOut & ~prev_q;

    // Next pending state and counter; a rise coinciding with fin re-arms the request.
    always_comb begin
        pend_d    = pend_q;
        missCnt_d = missCnt_q;
        if (EDGE) begin
            pend_d = rise | (pend_q & ~int_fin_i);
            if (miss_clr_i) begin
                missCnt_d = '0;
            end else if (rise && pend_q && !int_fin_i && (missCnt_q != {CNT_W{1'b1}})) begin
                missCnt_d = missCnt_q + 1'b1;
            end
        end else begin
            pend_d    = syncOut;
            missCnt_d = '0;
        end
    end

    // Synchroniser chain, previous-value flop, pending flop and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            pend_q    <= 1'b0;
            missCnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_raw_i};
            prev_q    <= syncOut;
            pend_q    <= pend_d;
            missCnt_q <= missCnt_d;
        end
    end

    assign pend_o      = pend_q;
    assign pend_next_o = pend_d;
    assign miss_cnt_o  = missCnt_q;

endmodule

// File: rtl/irq_request_unit.sv
// Interrupt request front end: one channel per source plus a registered
// any-request flag. SYNC_STAGES must be at least 2.
module irq_request_unit #(
    parameter int                       N_SRC       = irq_pkg::N_SRC,
    parameter int                       SYNC_STAGES = 2,
    parameter logic [irq_pkg::N_SRC-1:0] EDGE_MODE  = irq_pkg::EDGE_MODE_DEFAULT,
    parameter int                       CNT_W       = irq_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         irq_raw_i,
    input  logic [N_SRC-1:0]         int_fin_i,
    input  logic [N_SRC-1:0]         miss_clr_i,
    output logic [N_SRC-1:0]         int_req_o,
    output logic [N_SRC*CNT_W-1:0]   miss_cnt_o,
    output logic                     irq_any_o
);

    import irq_pkg::*;

    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pendNext;
    logic             irqAny_q;
    logic             irqAny_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_src_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EDGE_MODE[i]),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .irq_raw_i   (irq_raw_i[i]),
            .int_fin_i   (int_fin_i[i]),
            .miss_clr_i  (miss_clr_i[i]),
            .pend_o      (pend[i]),
            .pend_next_o (pendNext[i]),
            .miss_cnt_o  (miss_cnt_o[i*CNT_W +: CNT_W])
        );
    end

    assign irqAny_d = |pendNext;

    // Any-request flag registered from next pending values so it tracks int_req_o exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irqAny_q <= 1'b0;
        end else begin
            irqAny_q <= irqAny_d;
        end
    end

    assign int_req_o = pend;
    assign irq_any_o = irqAny_q;

endmodule

// File: tb/tb_irq_request_unit.sv
// Self-checking bench for irq_request_unit: directed vectors plus a short
// random regression against a cycle model.
module tb_irq_request_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  raw, fin, clr;
    logic [5:0]  req;
    logic [23:0] cnt;
    logic        any;

    logic [5:0]  rawL, finL, clrL;
    logic [5:0]  reqL;
    logic [23:0] cntL;
    logic        anyL;

    int checks   = 0;
    int failures = 0;

    // model state for the random regression
    logic [5:0]  mR1, mR2, mP, mPend, mS, mRise, mNext;
    logic [3:0]  mCnt [6];
    logic [23:0] mCntVec;
    logic        mAny;

    always #5 clk = ~clk;

    irq_request_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_raw_i  (raw),
        .int_fin_i  (fin),
        .miss_clr_i (clr),
        .int_req_o  (req),
        .miss_cnt_o (cnt),
        .irq_any_o  (any)
    );

    irq_request_unit #(.EDGE_MODE(6'b111110)) dutL (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_raw_i  (rawL),
        .int_fin_i  (finL),
        .miss_clr_i (clrL),
        .int_req_o  (reqL),
        .miss_cnt_o (cntL),
        .irq_any_o  (anyL)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] r, input logic [5:0] f, input logic [5:0] c);
        raw = r;
        fin = f;
        clr = c;
    endtask

    task automatic pulseSrc(input int idx);
        logic [5:0] v;
        v      = '0;
        v[idx] = 1'b1;
        applyStimulus(v, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(6'b0, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int asserts;
        logic prevBit;

        rst_n = 1'b0;
        applyStimulus(6'b0, 6'b0, 6'b0);
        rawL = '0; finL = '0; clrL = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req", req, 6'h00);
        checkOutput("reset_cnt", cnt, 24'h0);
        checkOutput("reset_any", any, 1'b0);
        checkOutput("reset_reqL", reqL, 6'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // single edge on source 2
        applyStimulus(6'b000100, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
        checkOutput("edge_not_yet", req, 6'h00);
        @(negedge clk);
        checkOutput("edge_req", req, 6'b000100);
        checkOutput("edge_any", any, 1'b1);
        applyStimulus(6'b0, 6'b0, 6'b0);
        @(negedge clk);
        applyStimulus(6'b0, 6'b000100, 6'b0);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);
        checkOutput("fin_clears_req", req, 6'h00);
        checkOutput("fin_clears_any", any, 1'b0);

        // missed events on source 0
        for (int i = 0; i < 4; i++) pulseSrc(0);
        checkOutput("miss_req0", req[0], 1'b1);
        checkOutput("miss_cnt3", cnt[3:0], 4'd3);
        for (int i = 0; i < 20; i++) pulseSrc(0);
        checkOutput("miss_sat15", cnt[3:0], 4'd15);
        applyStimulus(6'b0, 6'b0, 6'b000001);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);
        checkOutput("miss_clr", cnt[3:0], 4'd0);
        checkOutput("miss_clr_req_kept", req[0], 1'b1);
        applyStimulus(6'b0, 6'b000001, 6'b0);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);
        checkOutput("miss_fin0", req[0], 1'b0);

        // simultaneous rise and fin on source 1
        pulseSrc(1);
        pulseSrc(1);
        checkOutput("sim_cnt1_pre", cnt[7:4], 4'd1);
        applyStimulus(6'b000010, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
        applyStimulus(6'b000010, 6'b000010, 6'b0);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);
        checkOutput("sim_req1_kept", req[1], 1'b1);
        checkOutput("sim_cnt1_same", cnt[7:4], 4'd1);
        repeat (2) @(negedge clk);
        // clear coincident with an increment
        applyStimulus(6'b000010, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
        applyStimulus(6'b000010, 6'b0, 6'b000010);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);
        checkOutput("clr_wins", cnt[7:4], 4'd0);
        repeat (2) @(negedge clk);
        checkOutput("clr_wins_hold", cnt[7:4], 4'd0);
        checkOutput("clr_req1", req[1], 1'b1);
        applyStimulus(6'b0, 6'b000010, 6'b0);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);

        // level mode on source 0 of the second instance
        rawL = 6'b000001;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            checkOutput($sformatf("level_req_c%0d", i), reqL[0], (i >= 3 && i <= 12));
            if (i == 3) checkOutput("level_any", anyL, 1'b1);
            finL = (i == 6) ? 6'b000001 : 6'b0;
            if (i == 10) rawL = 6'b0;
        end
        checkOutput("level_cnt", cntL[3:0], 4'd0);

        // mid-operation reset with all sources pending
        applyStimulus(6'h3F, 6'b0, 6'b0);
        repeat (3) @(negedge clk);
        checkOutput("all_pending", req, 6'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_req", req, 6'h00);
        checkOutput("async_reset_cnt", cnt, 24'h0);
        checkOutput("async_reset_any", any, 1'b0);
        applyStimulus(6'b100000, 6'b0, 6'b0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        asserts = 0;
        prevBit = req[5];
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (req[5] && !prevBit) asserts++;
            prevBit = req[5];
            if (i == 3) checkOutput("release_req5", req[5], 1'b1);
            if (i == 5) applyStimulus(6'b100000, 6'b100000, 6'b0);
            else        applyStimulus(6'b100000, 6'b0, 6'b0);
        end
        checkOutput("release_one_event", asserts, 1);
        checkOutput("release_req5_cleared", req[5], 1'b0);
        applyStimulus(6'b0, 6'b0, 6'b0);
        repeat (3) @(negedge clk);

        // raw pulse narrower than one clock period, straddling a rising edge
        #3 raw = 6'b001000;
        #4 raw = 6'b000000;
        asserts = 0;
        prevBit = req[3];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req[3] && !prevBit) asserts++;
            prevBit = req[3];
        end
        checkOutput("short_pulse_single", (asserts <= 1), 1'b1);
        applyStimulus(6'b0, 6'b001000, 6'b0);
        @(negedge clk);
        applyStimulus(6'b0, 6'b0, 6'b0);

        // random regression against the cycle model
        doReset();
        mR1 = '0; mR2 = '0; mP = '0; mPend = '0; mAny = 1'b0;
        for (int i = 0; i < 6; i++) mCnt[i] = '0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(6'($urandom), 6'($urandom & $urandom),
                          ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b0);
            @(posedge clk);
            mS    = mR2;
            mRise = mS & ~mP;
            for (int i = 0; i < 6; i++) begin
                mNext[i] = mRise[i] ? 1'b1 : (fin[i] ? 1'b0 : mPend[i]);
                if (clr[i]) mCnt[i] = 4'd0;
                else if (mRise[i] && mPend[i] && !fin[i] && mCnt[i] != 4'd15) mCnt[i] = mCnt[i] + 4'd1;
            end
            mAny  = |mNext;
            mPend = mNext;
            mP    = mS;
            mR2   = mR1;
            mR1   = raw;
            for (int i = 0; i < 6; i++) mCntVec[i*4 +: 4] = mCnt[i];
            @(negedge clk);
            checkOutput($sformatf("rand_req_c%0d", c), req, mPend);
            checkOutput($sformatf("rand_cnt_c%0d", c), cnt, mCntVec);
            checkOutput($sformatf("rand_any_c%0d", c), any, mAny);
        end
        applyStimulus(6'b0, 6'b0, 6'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
